ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 10 +
 rtl/ifetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-ROM fetch bus between ifetch_unit (master) and the instruction memory (slave).
interface ifetch_unit_if;
   logic        irom_req;
   logic [31:0] irom_addr;
   logic        irom_rdy;
   logic [31:0] irom_rdata;

   modport master (output irom_req, output irom_addr, input irom_rdy, input irom_rdata);
   modport slave  (input irom_req, input irom_addr, output irom_rdy, output irom_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection and a request/hold FSM toward instruction ROM.
// Optional macro IFETCH_ADEF_EN: trap misaligned next PCs into a sticky halt instead of truncating them.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h1C000000,
   parameter logic [31:0] NOP_INST = 32'h03400000
) (
   input  logic         cpu_clk,
   input  logic         cpu_rst,
   input  logic [1:0]   npc_op,
   input  logic         br_taken,
   input  logic signed [31:0] offs,
   input  logic [31:0]  rj_val,
   input  logic         stall,
   ifetch_unit_if.master irom,
   output logic [31:0]  inst,
   output logic         inst_valid,
   output logic [31:0]  pc,
   output logic [31:0]  pc4,
   output logic         fetch_adef
);

   typedef enum logic [1:0] {S_REQ, S_VALID, S_HALT} state_t;

   state_t      state, state_nxt;
   logic        consume;
   logic        adef_hit;
   logic [31:0] npc_raw;
   logic [31:0] npc;

   // Address arithmetic wraps modulo 2^32; offs is already sign-extended.
   function automatic logic [31:0] calc_npc(input logic [1:0] op, input logic taken,
                                            input logic [31:0] cur, input logic signed [31:0] off,
                                            input logic [31:0] base);
      logic [31:0] seq;
      seq = cur + 32'd4;
      case (op)
         2'b00:   calc_npc = seq;
         2'b01:   calc_npc = taken ? (cur + off) : seq;
         2'b10:   calc_npc = base + off;
         default: calc_npc = cur + off;
      endcase
   endfunction

   assign npc_raw = calc_npc(npc_op, br_taken, pc, offs, rj_val);

`ifdef IFETCH_ADEF_EN
   assign npc      = npc_raw;
   assign adef_hit = (npc_raw[1:0] != 2'b00);
`else
   assign npc      = {npc_raw[31:2], 2'b00};
   assign adef_hit = 1'b0;
`endif

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) state <= S_REQ;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      consume   = 1'b0;
      case (state)
         S_REQ: begin
            if (irom.irom_rdy) state_nxt = S_VALID;
         end
         S_VALID: begin
            if (!stall) begin
               consume   = 1'b1;
               state_nxt = adef_hit ? S_HALT : S_REQ;
            end
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_REQ;
      endcase
   end

   // Held instruction and PC; a consume always empties the holding slot.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         pc         <= RESET_PC;
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
      end else if (state == S_REQ && irom.irom_rdy) begin
         inst       <= irom.irom_rdata;
         inst_valid <= 1'b1;
      end else if (consume) begin
         pc         <= npc;
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
      end
   end

`ifdef IFETCH_ADEF_EN
   logic adef_q;
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst)                 adef_q <= 1'b0;
      else if (consume && adef_hit) adef_q <= 1'b1;
   end
   assign fetch_adef = adef_q;
`else
   assign fetch_adef = 1'b0;
`endif

   assign irom.irom_req  = (state == S_REQ);
   assign irom.irom_addr = pc;
   assign pc4            = pc + 32'd4;

endmodule
